// File: rtl/mem_pkg.sv
// Shared definitions for the memory request arbiter: state encoding,
// default block geometry and the block-offset width helper.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    WRITE = 2'd3
  } arbStateT;

  localparam int DEF_WORDS_PER_BLOCK = 8;
  localparam int DEF_BYTES_PER_WORD  = 2;

  function automatic int blockOffsetW(input int wordsPerBlock, input int bytesPerWord);
    return $clog2(wordsPerBlock * bytesPerWord);
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational winner selection: lowest index in fixed mode, or the first
// requester strictly after the pointer (wrapping) in round-robin mode.
module rr_priority_select #(
  parameter int N_REQ   = 2,
  parameter int RR_MODE = 0
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         winner
);

  always_comb begin
    int   start;
    int   idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    start  = int'(ptr) + 1;
    if (RR_MODE == 0) start = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = start + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates cache controllers onto one pipelined memory: block fills of
// WORDS_PER_BLOCK back-to-back reads, or single-word write-through stores.
module mem_req_arbiter
  import mem_pkg::*;
#(
  parameter int N_REQ           = 2,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int BYTES_PER_WORD  = DEF_BYTES_PER_WORD,
  parameter int RR_MODE         = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_REQ-1:0]                   req,
  input  logic [N_REQ-1:0]                   req_wr,
  input  logic [N_REQ*ADDR_W-1:0]            req_addr,
  input  logic [N_REQ*DATA_W-1:0]            req_wdata,
  output logic [N_REQ-1:0]                   grant,
  output logic [N_REQ-1:0]                   stall,
  output logic [N_REQ-1:0]                   done,
  output logic                               mem_en,
  output logic                               mem_wr,
  output logic [ADDR_W-1:0]                  mem_addr,
  output logic [DATA_W-1:0]                  mem_wdata,
  input  logic [DATA_W-1:0]                  mem_rdata,
  input  logic                               mem_rvalid,
  output logic [N_REQ-1:0]                   fill_valid,
  output logic [DATA_W-1:0]                  fill_data,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_idx
);

  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int PTR_W = $clog2(N_REQ);
  localparam int OFF_W = blockOffsetW(WORDS_PER_BLOCK, BYTES_PER_WORD);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFF_W;
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0]  LAST_WORD  = IDX_W'(WORDS_PER_BLOCK - 1);

  arbStateT          state;
  logic [IDX_W-1:0]  issueCnt;
  logic [IDX_W-1:0]  rcvCnt;
  logic [PTR_W-1:0]  rrPtr;
  logic [N_REQ-1:0]  winner;
  logic [PTR_W-1:0]  winIdx;
  logic [ADDR_W-1:0] winAddr;
  logic [DATA_W-1:0] winData;
  logic              winWr;
  logic              readState;
  logic              rdBeat;
  logic              lastBeat;

  rr_priority_select #(
    .N_REQ   (N_REQ),
    .RR_MODE (RR_MODE)
  ) uSelect (
    .req    (req),
    .ptr    (rrPtr),
    .winner (winner)
  );

  always_comb begin
    winIdx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner[i]) winIdx = PTR_W'(i);
    end
  end

  assign winAddr = req_addr[int'(winIdx)*ADDR_W +: ADDR_W];
  assign winData = req_wdata[int'(winIdx)*DATA_W +: DATA_W];
  assign winWr   = req_wr[winIdx];

  // Returned words are only accepted while a block read owns the memory.
  assign readState  = (state == ISSUE) || (state == DRAIN);
  assign rdBeat     = readState && mem_rvalid;
  assign lastBeat   = rdBeat && (rcvCnt == LAST_WORD);
  assign fill_valid = rdBeat ? grant : '0;
  assign fill_data  = mem_rdata;
  assign fill_idx   = rcvCnt;
  assign done       = (lastBeat || (state == WRITE)) ? grant : '0;
  assign stall      = req & ~done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      grant     <= '0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      issueCnt  <= '0;
      rcvCnt    <= '0;
      rrPtr     <= PTR_W'(N_REQ - 1);
    end else begin
      if (rdBeat) rcvCnt <= rcvCnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (|req) begin
            grant  <= winner;
            mem_en <= 1'b1;
            if (RR_MODE != 0) rrPtr <= winIdx;
            if (winWr) begin
              state     <= WRITE;
              mem_wr    <= 1'b1;
              mem_addr  <= winAddr;
              mem_wdata <= winData;
            end else begin
              state    <= ISSUE;
              mem_addr <= winAddr & ALIGN_MASK;
            end
          end
        end
        ISSUE: begin
          issueCnt <= issueCnt + 1'b1;
          if (issueCnt == LAST_WORD) begin
            mem_en <= 1'b0;
            state  <= DRAIN;
          end else begin
            mem_addr <= mem_addr + ADDR_STEP;
          end
        end
        DRAIN: begin
          if (lastBeat) begin
            state <= IDLE;
            grant <= '0;
          end
        end
        WRITE: begin
          state  <= IDLE;
          grant  <= '0;
          mem_en <= 1'b0;
          mem_wr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: fixed-priority instance with a memory model and
// scoreboard, plus a round-robin instance for grant-order checks.
module tb_mem_req_arbiter;

  localparam int L = 4;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } memExpT;

  typedef struct packed {
    logic [1:0]  fv;
    logic [2:0]  idx;
    logic [15:0] data;
  } fillExpT;

  typedef struct {
    int          ch;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    int          dropCyc;
  } vecT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          nVec = 0;
  int          nMis = 0;

  // fixed-priority instance
  logic [1:0]  req = '0, reqWr = '0;
  logic [31:0] reqAddr = '0, reqWdata = '0;
  logic [1:0]  grant, stall, done, fillValid;
  logic        memEn, memWr, memRvalid;
  logic [15:0] memAddr, memWdata, memRdata, fillData;
  logic [2:0]  fillIdx;

  // round-robin instance
  logic [1:0]  rReq = '0;
  logic [1:0]  rGrant, rStall, rDone, rFillValid;
  logic        rMemEn, rMemWr, rRvalid;
  logic [15:0] rMemAddr, rMemWdata, rFillData;
  logic [15:0] rMemRdata = 16'h00A5;
  logic [2:0]  rFillIdx;

  memExpT      memQ[$];
  fillExpT     fillQ[$];
  memExpT      monMem;
  fillExpT     monFill;
  vecT         vec[6];

  logic [L-1:0] vPipe = '0;
  logic [L-1:0] rPipe = '0;
  logic [15:0]  aPipe[L];
  logic         injRv = 1'b0;

  always #5 clk = ~clk;

  mem_req_arbiter #(.N_REQ(2), .ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(8),
                    .BYTES_PER_WORD(2), .RR_MODE(0)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr(reqWr), .req_addr(reqAddr),
    .req_wdata(reqWdata), .grant(grant), .stall(stall), .done(done),
    .mem_en(memEn), .mem_wr(memWr), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_rdata(memRdata), .mem_rvalid(memRvalid), .fill_valid(fillValid),
    .fill_data(fillData), .fill_idx(fillIdx)
  );

  mem_req_arbiter #(.N_REQ(2), .ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(8),
                    .BYTES_PER_WORD(2), .RR_MODE(1)) dutRr (
    .clk(clk), .rst(rst), .req(rReq), .req_wr(2'b00), .req_addr(32'h2000_1000),
    .req_wdata(32'h0), .grant(rGrant), .stall(rStall), .done(rDone),
    .mem_en(rMemEn), .mem_wr(rMemWr), .mem_addr(rMemAddr), .mem_wdata(rMemWdata),
    .mem_rdata(rMemRdata), .mem_rvalid(rRvalid), .fill_valid(rFillValid),
    .fill_data(rFillData), .fill_idx(rFillIdx)
  );

  function automatic logic [15:0] rdFn(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // Memory models: one read beat returned L cycles after each read issue.
  always @(posedge clk) begin
    vPipe    <= {vPipe[L-2:0], memEn & ~memWr};
    rPipe    <= {rPipe[L-2:0], rMemEn & ~rMemWr};
    aPipe[0] <= memAddr;
    for (int k = 1; k < L; k++) aPipe[k] <= aPipe[k-1];
  end
  assign memRvalid = vPipe[L-1] | injRv;
  assign memRdata  = rdFn(aPipe[L-1]);
  assign rRvalid   = rPipe[L-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void pushRead(input logic [1:0] oh, input logic [15:0] addr);
    logic [15:0] a;
    for (int i = 0; i < 8; i++) begin
      a = (addr & 16'hFFF0) + 16'(2 * i);
      memQ.push_back('{1'b0, a, 16'h0000});
      fillQ.push_back('{oh, 3'(i), rdFn(a)});
    end
  endfunction

  // Scoreboard: every issue and every returned word is matched in order.
  always @(negedge clk) begin
    if (rst && memEn) begin
      if (memQ.size() == 0) chk("mem_en_unexpected", memEn, 1'b0);
      else begin
        monMem = memQ.pop_front();
        chk("mem_wr", memWr, monMem.wr);
        chk("mem_addr", memAddr, monMem.addr);
        if (monMem.wr) chk("mem_wdata", memWdata, monMem.wdata);
      end
    end
    if (rst && fillValid != 2'b00) begin
      if (fillQ.size() == 0) chk("fill_unexpected", fillValid, 2'b00);
      else begin
        monFill = fillQ.pop_front();
        chk("fill_valid", fillValid, monFill.fv);
        chk("fill_idx", fillIdx, monFill.idx);
        chk("fill_data", fillData, monFill.data);
      end
    end
  end

  task automatic doTxn(input vecT v);
    logic [1:0] oh;
    int         got;
    int         cnt;
    int         stallBad;
    oh = 2'b01 << v.ch;
    if (v.wr) memQ.push_back('{1'b1, v.addr, v.wdata});
    else pushRead(oh, v.addr);
    @(posedge clk); #1;
    req[v.ch]                = 1'b1;
    reqWr[v.ch]              = v.wr;
    reqAddr[v.ch*16 +: 16]   = v.addr;
    reqWdata[v.ch*16 +: 16]  = v.wdata;
    if (v.wr) injRv = 1'b1;
    @(negedge clk);
    chk("idle_stall", stall, oh);
    chk("idle_grant", grant, 2'b00);
    got      = -1;
    cnt      = 0;
    stallBad = 0;
    while (got < 0 && cnt < 40) begin
      @(posedge clk);
      cnt++;
      if (cnt == v.dropCyc) begin
        #1 req[v.ch] = 1'b0;
      end
      @(negedge clk);
      if (cnt == 1) chk("grant", grant, oh);
      if (v.dropCyc > 0 && cnt >= v.dropCyc && stall != 2'b00) stallBad++;
      if (done != 2'b00) begin
        got = cnt;
        chk("done_vec", done, oh);
        chk("done_stall", stall, 2'b00);
      end
    end
    chk("latency", got, v.lat);
    if (v.dropCyc > 0) chk("drop_stall", stallBad, 0);
    @(posedge clk); #1;
    req   = '0;
    reqWr = '0;
    injRv = 1'b0;
    @(negedge clk);
    chk("post_grant", grant, 2'b00);
    chk("mem_q_left", memQ.size(), 0);
    chk("fill_q_left", fillQ.size(), 0);
  endtask

  initial begin
    int         d0, d1, bad, nd, fills;
    logic [1:0] g1;
    logic [1:0] ord[3];
    int         dc[3];

    vec[0] = '{0, 1'b0, 16'h1236, 16'h0000, 12, 0};
    vec[1] = '{1, 1'b1, 16'h0045, 16'hBEEF, 1, 0};
    vec[2] = '{1, 1'b0, 16'hFFF1, 16'h0000, 12, 0};
    vec[3] = '{0, 1'b1, 16'h1237, 16'h1234, 1, 0};
    vec[4] = '{0, 1'b0, 16'h5008, 16'h0000, 12, 5};
    vec[5] = '{1, 1'b0, 16'h00AF, 16'h0000, 12, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {grant, done, memEn, memWr, memAddr, memWdata, fillValid}, 40'h0);
    chk("reset_outputs_rr", {rGrant, rDone, rMemEn, rMemWr, rMemAddr}, 22'h0);
    @(posedge clk); #1 rst = 1'b1;

    for (int i = 0; i < 6; i++) doTxn(vec[i]);

    // Both channels request reads together: channel 0 first, channel 1 next.
    pushRead(2'b01, 16'h2000);
    pushRead(2'b10, 16'h3010);
    @(posedge clk); #1;
    req     = 2'b11;
    reqWr   = 2'b00;
    reqAddr = {16'h3010, 16'h2000};
    d0 = -1; d1 = -1; bad = 0; g1 = '0;
    @(negedge clk);
    if (!stall[1]) bad++;
    for (int c = 0; c < 60 && d1 < 0; c++) begin
      @(posedge clk); #1;
      if (d0 >= 0 && req[0]) req[0] = 1'b0;
      @(negedge clk);
      if (!stall[1] && !done[1]) bad++;
      if (done[0]) d0 = c + 1;
      if (done[1]) d1 = c + 1;
      if (c + 1 == 14) g1 = grant;
    end
    @(posedge clk); #1 req = '0;
    chk("dual_done0", d0, 12);
    chk("dual_done1", d1, 25);
    chk("dual_grant1", g1, 2'b10);
    chk("dual_stall1", bad, 0);
    chk("dual_q_left", memQ.size() + fillQ.size(), 0);

    // Round-robin with both requests held for three transactions.
    @(posedge clk); #1 rReq = 2'b11;
    nd = 0; fills = 0;
    for (int c = 0; c < 60 && nd < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (rFillValid != 2'b00) fills++;
      if (rDone != 2'b00) begin
        ord[nd] = rDone;
        dc[nd]  = c + 1;
        if (nd == 0) begin
          chk("rr_stall", rStall, 2'b10);
          chk("rr_fill_idx", rFillIdx, 3'd7);
          chk("rr_fill_data", rFillData, 16'h00A5);
        end
        nd++;
      end
    end
    @(posedge clk); #1 rReq = '0;
    chk("rr_count", nd, 3);
    if (nd == 3) begin
      chk("rr_order0", ord[0], 2'b01);
      chk("rr_order1", ord[1], 2'b10);
      chk("rr_order2", ord[2], 2'b01);
      chk("rr_lat0", dc[0], 12);
      chk("rr_lat1", dc[1], 25);
      chk("rr_lat2", dc[2], 38);
    end
    chk("rr_fills", fills, 24);
    chk("rr_no_write", {rMemWr, rMemWdata}, 17'h0);

    // Reset after the third returned word aborts the fill.
    pushRead(2'b01, 16'h4000);
    @(posedge clk); #1;
    req[0]          = 1'b1;
    reqWr[0]        = 1'b0;
    reqAddr[15:0]   = 16'h4002;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_fill", {fillValid, fillIdx}, {2'b01, 3'd2});
    #1;
    rst = 1'b0;
    req = '0;
    #1;
    chk("async_reset_outputs",
        {grant, done, memEn, memWr, memAddr, memWdata, fillValid, stall}, 42'h0);
    memQ.delete();
    fillQ.delete();
    @(posedge clk); #1 rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("stray_fill", {fillValid, memEn}, 3'b000);
    end
    doTxn('{0, 1'b0, 16'h4444, 16'h0000, 12, 0});

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
